// File: rtl/serial_adder_if.sv
// Operand/result bundle for the bit-serial adder.
// The driver holds master; the adder holds slave.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder built on one full_adder slice.
// One result every WIDTH+1 cycles under a start/busy/done handshake.
module full_adder (
  output logic sum,
  output logic cout,
  input  logic a,
  input  logic b,
  input  logic cin
);
  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_adder_if.slave    bus
);
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_s_sh;
  logic [WIDTH-1:0] r_sum;
  logic [WIDTH-1:0] w_s_nxt;
  logic             r_carry;
  logic             r_cout;
  logic [CW-1:0]    r_cnt;
  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_load;
  logic             w_last;

  full_adder u_fa (
    .sum  (w_fa_s),
    .cout (w_fa_c),
    .a    (r_a_sh[0]),
    .b    (r_b_sh[0]),
    .cin  (r_carry)
  );

  // Slice sum enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_s_nxt = w_fa_s;
    end else begin : g_wn
      assign w_s_nxt = {w_fa_s, r_s_sh[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_load = 1'b1;
          w_next = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        w_load = bus.start;
        w_next = bus.start ? S_SHIFT : S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_s_sh  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_load) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_carry <= bus.cin;
      r_cnt   <= '0;
    end else if (r_state == S_SHIFT) begin
      r_s_sh  <= w_s_nxt;
      r_a_sh  <= r_a_sh >> 1;
      r_b_sh  <= r_b_sh >> 1;
      r_carry <= w_fa_c;
      r_cnt   <= r_cnt + CW'(1);
      if (w_last) begin
        r_sum  <= w_s_nxt;
        r_cout <= w_fa_c;
      end
    end
  end

  assign bus.busy = (r_state == S_SHIFT);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial adder that adds two WIDTH-bit operands LSB-first over WIDTH clock cycles. It uses a single instance of the team's one-bit `full_adder` cell (ports sum, cout, a, b, cin) as its arithmetic slice and a carry flip-flop to chain bits across cycles. Operands are captured under a start/busy/done handshake. The result and final carry are presented as registered outputs. The block sits directly downstream of the adder cell and trades area for latency in datapaths where a WIDTH-bit ripple adder is too large.

## Interface
- WIDTH, default 8: operand and result width in bits; legal range ≥ 1.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an addition; sampled only when not busy.
- a  input  WIDTH  operand A, captured on accepted start.
- b  input  WIDTH  operand B, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while bits are being processed.
- done  output  1  one-cycle pulse: sum/cout just updated.
- sum  output  WIDTH  registered result, held until the next completion.
- cout  output  1  registered final carry-out, held with sum.

## Operation
- Internal state:
  - a_sh and b_sh: WIDTH-bit right-shift registers.
  - s_sh: WIDTH-bit result shift register.
  - carry: 1-bit carry flip-flop.
  - cnt: bit counter, width $clog2(WIDTH+1), min 1.
  - FSM states IDLE, SHIFT, DONE.
- Slice connections: full_adder a=a_sh[0], b=b_sh[0], cin=carry. Its sum and cout feed the registers below.
- IDLE:
  - busy=0, done=0.
  - If start=1: a_sh←a, b_sh←b, carry←cin, cnt←0, go to SHIFT.
- SHIFT, on each edge:
  - s_sh←{slice sum, s_sh[WIDTH-1:1]}.
  - a_sh and b_sh shift right by one, zero fill.
  - carry←slice cout.
  - cnt←cnt+1.
  - On the edge where cnt==WIDTH-1: sum←{slice sum, s_sh[WIDTH-1:1]}, cout←slice cout, go to DONE.
  - start is ignored throughout SHIFT. Operands cannot be reloaded mid-operation.
- DONE (one cycle):
  - busy=0, done=1.
  - If start=1: capture new operands exactly as in IDLE and go to SHIFT (back-to-back operation).
  - Otherwise go to IDLE.
- Arithmetic: {cout,sum} = a + b + cin, mod 2^(WIDTH+1). No overflow flag.
- sum and cout change only on the completion edge. They never show partial results.
- Input a/b/cin values outside the accepted-start cycle have no effect.

## Timing
- Reset (rst_n=0 at a rising edge):
  - State→IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - a_sh, b_sh, s_sh, carry and cnt cleared.
  - rst_n is not in any sensitivity list except via clk.
- Reset mid-SHIFT aborts the operation: no done pulse, sum/cout cleared to 0.
- Reset dominates a start asserted in the same cycle.
- Latency:
  - Start accepted at edge E0.
  - busy is high in the WIDTH cycles following E0.
  - The completion edge is E0+WIDTH. done is high for the one cycle after it, with sum/cout valid.
- Throughput: with start held high, one result every WIDTH+1 cycles.
- WIDTH=1: a single SHIFT cycle. The cnt==WIDTH-1 test is true on the first SHIFT edge.
- A start arriving during busy is dropped, not queued. The source must wait for busy=0.
- No combinational paths from inputs to outputs. All outputs are registered.

## Test plan
- Basic add, WIDTH=8: a=0x5A, b=0x3C, cin=0, start pulsed.
  - busy high exactly 8 cycles.
  - done pulses once with sum=0x96, cout=0.
- Carry ripple through all bits:
  - a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1.
  - a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start during busy: pulse start with a=0x01, b=0x01 at cycle 3 of an active 0x10+0x20 operation.
  - Ignored; result sum=0x30, cout=0.
  - Only one done pulse.
- Back-to-back: start held high across two operations, 0x0F+0x01 then 0x80+0x80.
  - First done shows sum=0x10, cout=0.
  - Second operation is accepted in that DONE cycle.
  - The next done, WIDTH+1 cycles later, shows sum=0x00, cout=1.
- Reset mid-operation: rst_n=0 for one cycle at SHIFT cycle 4.
  - busy=0, sum=0, cout=0 after the edge; no done.
  - A subsequent 0x03+0x04 completes normally with sum=0x07.
- WIDTH=1 exhaustive: all 8 combinations of a, b, cin.
  - busy high 1 cycle each.
  - {cout,sum} equals the arithmetic sum.
